amo_mem_responder: RTL and testbench
====================================

// Module: amo_mem_responder
// PURPOSE
//  Memory-side responder for the core data port. Serves core and DMA requests
//  to a single-port SRAM with 1-cycle read latency. Keeps AMO read-modify-write
//  sequences atomic by locking out the DMA between the locked read and the
//  following write. Tracks the LR/SC reservation and resolves SC success/fail.
// PARAMETERS
//  ADDR_WIDTH     32  byte address width (word = addr[ADDR_WIDTH-1:2])
//  LOCK_TIMEOUT    8  cycles in LOCKED without the releasing write before forced release
// PORTS
//  clk             in   1   clock, all logic on rising edge
//  reset_n         in   1   synchronous active-low reset
//  core_req_i      in   1   core access request
//  core_we_i       in   4   core byte write enables (0 = read)
//  core_lock_i     in   1   with a read: AMO load, enter LOCKED
//  core_lr_i       in   1   with a read: load-reserved
//  core_sc_i       in   1   with a write: store-conditional
//  core_addr_i     in   AW  core byte address
//  core_data_i     in   32  core write data
//  core_gnt_o      out  1   core request accepted this cycle
//  core_rvalid_o   out  1   core read data valid
//  core_data_o     out  32  core read data
//  sc_done_o       out  1   SC resolved (1 cycle after SC grant)
//  sc_fail_o       out  1   SC result, valid with sc_done_o (0 = success)
//  dma_req_i       in   1   DMA access request
//  dma_we_i        in   4   DMA byte write enables (0 = read)
//  dma_addr_i      in   AW  DMA byte address
//  dma_data_i      in   32  DMA write data
//  dma_gnt_o       out  1   DMA request accepted this cycle
//  dma_rvalid_o    out  1   DMA read data valid
//  dma_data_o      out  32  DMA read data
//  mem_en_o        out  1   SRAM enable
//  mem_we_o        out  4   SRAM byte write enables
//  mem_addr_o      out  AW  SRAM address
//  mem_data_o      out  32  SRAM write data
//  mem_data_i      in   32  SRAM read data, valid 1 cycle after read enable
//  lock_timeout_o  out  1   1-cycle pulse on forced lock release
// BEHAVIOUR
//  - Reset (sync): state IDLE, priority to core, lock/reservation cleared;
//    all gnt/rvalid/sc_done/mem_en/mem_we/lock_timeout_o = 0; data outputs 0.
//  - At most one grant per cycle. Grant is combinational from req and state;
//    mem_* driven from the granted request in the same cycle.
//  - IDLE: single requester is granted. Both requesting: the master granted
//    less recently wins (round-robin, core first after reset).
//  - Granted core read with core_lock_i -> LOCKED; store lock word, clear counter.
//  - LOCKED: dma_gnt_o = 0. Core reads/writes granted. A core write to the lock
//    word -> IDLE on the next edge. Counter increments each LOCKED cycle without
//    that write; reaching LOCK_TIMEOUT-1 -> IDLE and pulse lock_timeout_o.
//    A locked read issued while LOCKED reloads the lock word and clears the counter.
//  - Read return: rvalid goes to the read's owner exactly 1 cycle after its
//    grant. data_o = mem_data_i on that cycle and holds the value otherwise.
//    Owner is registered at grant, so back-to-back reads of mixed owners work.
//  - LR: granted core read with core_lr_i sets resv_valid and resv_word.
//  - SC: granted core write with core_sc_i. If resv_valid and word match ->
//    mem_we_o = core_we_i, else mem_we_o = 0 (mem_en_o still 1). Reservation
//    is cleared either way; sc_done_o = 1 next cycle with sc_fail_o.
//  - DMA write granted to resv_word clears resv_valid. Same-cycle LR and DMA
//    write cannot occur (one grant per cycle).
//  - Reset mid-LOCKED or with read in flight: state dropped, no rvalid issued.
// TESTING
//  1 core rd 0x100, mem=0xDEADBEEF -> gnt cyc0, core_rvalid_o=1 & data=0xDEADBEEF cyc1
//  2 core+dma req 3 cycles -> gnts alternate core,dma,core; no simultaneous grant
//  3 core lock rd 0x40, dma req held; core wr 0x40 on cyc3 -> dma_gnt_o first at cyc4
//  4 lock rd 0x40, no write, LOCK_TIMEOUT=8 -> lock_timeout_o pulse, dma granted next
//  5 LR 0x80; dma wr 0x80; SC 0x80 -> mem_we_o=0, sc_done=1 & sc_fail=1; repeat w/o dma -> fail=0
//  6 reset_n=0 cycle after core rd grant -> core_rvalid_o stays 0, state IDLE

Source files
------------

// File: rtl/amo_mem_responder.sv
// Memory-side responder: arbitrates core/DMA onto a 1-cycle-latency SRAM,
// holds AMO read-modify-write sequences atomic and resolves LR/SC.
module amo_mem_responder #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned LOCK_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  core_req_i,
    input  logic [3:0]            core_we_i,
    input  logic                  core_lock_i,
    input  logic                  core_lr_i,
    input  logic                  core_sc_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [31:0]           core_data_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic [31:0]           core_data_o,
    output logic                  sc_done_o,
    output logic                  sc_fail_o,
    input  logic                  dma_req_i,
    input  logic [3:0]            dma_we_i,
    input  logic [ADDR_WIDTH-1:0] dma_addr_i,
    input  logic [31:0]           dma_data_i,
    output logic                  dma_gnt_o,
    output logic                  dma_rvalid_o,
    output logic [31:0]           dma_data_o,
    output logic                  mem_en_o,
    output logic [3:0]            mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_data_o,
    input  logic [31:0]           mem_data_i,
    output logic                  lock_timeout_o
);

    localparam int unsigned WORD_W = ADDR_WIDTH - 2;
    localparam int unsigned CNT_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [WORD_W-1:0]   r_lock_word;
    logic [WORD_W-1:0]   w_lock_word_nxt;
    logic                w_timeout;
    logic                r_lock_timeout;

    logic                r_last_core;
    logic                r_resv_valid;
    logic [WORD_W-1:0]   r_resv_word;

    logic                r_core_rvalid;
    logic                r_dma_rvalid;
    logic [31:0]         r_core_data;
    logic [31:0]         r_dma_data;
    logic                r_sc_done;
    logic                r_sc_fail;

    logic                w_core_gnt;
    logic                w_dma_gnt;
    logic                w_core_rd;
    logic                w_core_wr;
    logic                w_core_sc;
    logic                w_dma_rd;
    logic                w_dma_wr;
    logic                w_sc_ok;
    logic                w_sc_drop;
    logic [WORD_W-1:0]   w_core_word;
    logic [WORD_W-1:0]   w_dma_word;

    assign w_core_word = core_addr_i[ADDR_WIDTH-1:2];
    assign w_dma_word  = dma_addr_i[ADDR_WIDTH-1:2];
    assign w_sc_ok     = r_resv_valid && (r_resv_word == w_core_word);
    assign w_sc_drop   = core_sc_i && !w_sc_ok;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_lock_word    <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_lock_word    <= w_lock_word_nxt;
            r_lock_timeout <= w_timeout;
        end
    end

    // Output logic: grant arbitration and SRAM command for the granted master
    always_comb begin
        w_core_gnt = 1'b0;
        w_dma_gnt  = 1'b0;
        mem_en_o   = 1'b0;
        mem_we_o   = '0;
        mem_addr_o = '0;
        mem_data_o = '0;
        if (reset_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (core_req_i && (!dma_req_i || !r_last_core)) begin
                        w_core_gnt = 1'b1;
                    end else if (dma_req_i) begin
                        w_dma_gnt = 1'b1;
                    end
                end
                ST_LOCKED: w_core_gnt = core_req_i;
                default: ;
            endcase
        end
        // A failing SC still occupies the SRAM slot but writes no bytes
        if (w_core_gnt) begin
            mem_en_o   = 1'b1;
            mem_we_o   = w_sc_drop ? 4'b0000 : core_we_i;
            mem_addr_o = core_addr_i;
            mem_data_o = core_data_i;
        end else if (w_dma_gnt) begin
            mem_en_o   = 1'b1;
            mem_we_o   = dma_we_i;
            mem_addr_o = dma_addr_i;
            mem_data_o = dma_data_i;
        end
    end

    assign w_core_rd = w_core_gnt && (core_we_i == 4'b0000);
    assign w_core_wr = w_core_gnt && (core_we_i != 4'b0000);
    assign w_core_sc = w_core_wr && core_sc_i;
    assign w_dma_rd  = w_dma_gnt && (dma_we_i == 4'b0000);
    assign w_dma_wr  = w_dma_gnt && (dma_we_i != 4'b0000);

    // Next-state logic: lock entry, release by write, forced release on timeout
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_lock_word_nxt = r_lock_word;
        w_timeout       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_core_rd && core_lock_i) begin
                    w_state_nxt     = ST_LOCKED;
                    w_cnt_nxt       = '0;
                    w_lock_word_nxt = w_core_word;
                end
            end
            ST_LOCKED: begin
                if (w_core_wr && (w_core_word == r_lock_word)) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_core_rd && core_lock_i) begin
                    w_cnt_nxt       = '0;
                    w_lock_word_nxt = w_core_word;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Round-robin memory: which master won most recently
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_core <= 1'b0;
        end else if (w_core_gnt) begin
            r_last_core <= 1'b1;
        end else if (w_dma_gnt) begin
            r_last_core <= 1'b0;
        end
    end

    // LR/SC reservation and SC result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_resv_valid <= 1'b0;
            r_resv_word  <= '0;
            r_sc_done    <= 1'b0;
            r_sc_fail    <= 1'b0;
        end else begin
            r_sc_done <= w_core_sc;
            r_sc_fail <= w_core_sc && !w_sc_ok;
            if (w_core_sc) begin
                r_resv_valid <= 1'b0;
            end else if (w_core_rd && core_lr_i) begin
                r_resv_valid <= 1'b1;
                r_resv_word  <= w_core_word;
            end else if (w_dma_wr && (w_dma_word == r_resv_word)) begin
                r_resv_valid <= 1'b0;
            end
        end
    end

    // Read return: owner tagged at grant, data captured on its return cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_core_rvalid <= 1'b0;
            r_dma_rvalid  <= 1'b0;
            r_core_data   <= '0;
            r_dma_data    <= '0;
        end else begin
            r_core_rvalid <= w_core_rd;
            r_dma_rvalid  <= w_dma_rd;
            if (r_core_rvalid) begin
                r_core_data <= mem_data_i;
            end
            if (r_dma_rvalid) begin
                r_dma_data <= mem_data_i;
            end
        end
    end

    assign core_gnt_o     = w_core_gnt;
    assign dma_gnt_o      = w_dma_gnt;
    assign core_rvalid_o  = r_core_rvalid;
    assign dma_rvalid_o   = r_dma_rvalid;
    assign core_data_o    = r_core_rvalid ? mem_data_i : r_core_data;
    assign dma_data_o     = r_dma_rvalid ? mem_data_i : r_dma_data;
    assign sc_done_o      = r_sc_done;
    assign sc_fail_o      = r_sc_fail;
    assign lock_timeout_o = r_lock_timeout;

endmodule

// File: tb/tb_amo_mem_responder.sv
// Bench for amo_mem_responder: SRAM model, per-cycle behavioural reference and
// directed scenarios with hand-computed expectations.
module tb_amo_mem_responder;

    localparam int unsigned AW = 32;
    localparam int unsigned LT = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          core_req_i, core_lock_i, core_lr_i, core_sc_i;
    logic [3:0]    core_we_i;
    logic [AW-1:0] core_addr_i;
    logic [31:0]   core_data_i;
    logic          core_gnt_o, core_rvalid_o, sc_done_o, sc_fail_o;
    logic [31:0]   core_data_o;
    logic          dma_req_i;
    logic [3:0]    dma_we_i;
    logic [AW-1:0] dma_addr_i;
    logic [31:0]   dma_data_i;
    logic          dma_gnt_o, dma_rvalid_o;
    logic [31:0]   dma_data_o;
    logic          mem_en_o;
    logic [3:0]    mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_data_o;
    logic [31:0]   mem_data_i = 32'h0;
    logic          lock_timeout_o;

    always #5 clk = ~clk;

    amo_mem_responder #(.ADDR_WIDTH(AW), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .reset_n(reset_n),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_lock_i(core_lock_i),
        .core_lr_i(core_lr_i), .core_sc_i(core_sc_i), .core_addr_i(core_addr_i),
        .core_data_i(core_data_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_data_o(core_data_o), .sc_done_o(sc_done_o), .sc_fail_o(sc_fail_o),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
        .dma_data_i(dma_data_i), .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o),
        .dma_data_o(dma_data_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .lock_timeout_o(lock_timeout_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return (i == 8'h40) ? 32'hDEADBEEF : (32'hA500_0000 ^ (32'(i) * 32'h0001_0203));
    endfunction

    // SRAM: 1-cycle read latency, byte writes
    logic [31:0] sram [0:255];
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o == 4'b0000) begin
                mem_data_i <= sram[mem_addr_o[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_we_o[b]) sram[mem_addr_o[9:2]][8*b +: 8] = mem_data_o[8*b +: 8];
            end
        end
    end

    logic rst_at_edge = 1'b1;
    always @(posedge clk) rst_at_edge <= !reset_n;

    // Reference model state
    logic [31:0] ref_mem [0:255];
    bit          m_locked, m_core_turn, m_resv_valid, m_sc_done, m_sc_fail, m_timeout;
    logic [29:0] m_lock_word, m_resv_word;
    int          m_age, m_pend;
    logic [31:0] m_pend_data, m_core_last, m_dma_last;

    always @(negedge clk) begin : cmp
        logic        e_cg, e_dg, e_en, e_sc_ok, e_wr;
        logic [3:0]  e_we;
        logic [AW-1:0] e_addr;
        logic [31:0] e_wd;
        logic [29:0] cw;
        if (rst_at_edge) begin
            m_locked = 0; m_core_turn = 1; m_resv_valid = 0; m_sc_done = 0; m_sc_fail = 0;
            m_timeout = 0; m_lock_word = '0; m_resv_word = '0; m_age = 0; m_pend = 0;
            m_pend_data = '0; m_core_last = '0; m_dma_last = '0;
        end
        cw = core_addr_i[AW-1:2];
        e_cg = 0; e_dg = 0;
        if (reset_n) begin
            if (m_locked) e_cg = core_req_i;
            else if (core_req_i && dma_req_i) begin e_cg = m_core_turn; e_dg = !m_core_turn; end
            else begin e_cg = core_req_i; e_dg = dma_req_i; end
        end
        e_sc_ok = m_resv_valid && (m_resv_word == cw);
        e_en = e_cg || e_dg;
        e_we = 4'b0; e_addr = '0; e_wd = '0;
        if (e_cg) begin
            e_we = (core_sc_i && !e_sc_ok) ? 4'b0 : core_we_i;
            e_addr = core_addr_i; e_wd = core_data_i;
        end else if (e_dg) begin
            e_we = dma_we_i; e_addr = dma_addr_i; e_wd = dma_data_i;
        end
        chk("core_gnt", core_gnt_o, e_cg);
        chk("dma_gnt", dma_gnt_o, e_dg);
        chk("mem_en", mem_en_o, e_en);
        chk("mem_we", mem_we_o, e_we);
        if (e_en) begin
            chk("mem_addr", mem_addr_o, e_addr);
            chk("mem_wdata", mem_data_o, e_wd);
        end
        chk("core_rvalid", core_rvalid_o, m_pend == 1);
        chk("dma_rvalid", dma_rvalid_o, m_pend == 2);
        chk("core_rdata", core_data_o, (m_pend == 1) ? m_pend_data : m_core_last);
        chk("dma_rdata", dma_data_o, (m_pend == 2) ? m_pend_data : m_dma_last);
        chk("sc_done", sc_done_o, m_sc_done);
        if (m_sc_done) chk("sc_fail", sc_fail_o, m_sc_fail);
        chk("lock_timeout", lock_timeout_o, m_timeout);

        if (reset_n) begin
            if (m_pend == 1) m_core_last = m_pend_data;
            if (m_pend == 2) m_dma_last = m_pend_data;
            m_pend = 0;
            if (e_cg && core_we_i == 4'b0) begin m_pend = 1; m_pend_data = ref_mem[core_addr_i[9:2]]; end
            if (e_dg && dma_we_i == 4'b0) begin m_pend = 2; m_pend_data = ref_mem[dma_addr_i[9:2]]; end
            for (int b = 0; b < 4; b++)
                if (e_we[b]) ref_mem[e_addr[9:2]][8*b +: 8] = e_wd[8*b +: 8];
            e_wr = e_cg && core_we_i != 4'b0;
            m_sc_done = e_wr && core_sc_i;
            m_sc_fail = m_sc_done && !e_sc_ok;
            if (m_sc_done) m_resv_valid = 0;
            else if (e_cg && !e_wr && core_lr_i) begin m_resv_valid = 1; m_resv_word = cw; end
            else if (e_dg && dma_we_i != 4'b0 && dma_addr_i[AW-1:2] == m_resv_word) m_resv_valid = 0;
            m_timeout = 0;
            if (m_locked && e_wr && cw == m_lock_word) m_locked = 0;
            else if (e_cg && !e_wr && core_lock_i) begin m_locked = 1; m_lock_word = cw; m_age = 0; end
            else if (m_locked) begin
                m_age++;
                if (m_age == LT) begin m_locked = 0; m_timeout = 1; end
            end
            if (e_cg) m_core_turn = 0;
            else if (e_dg) m_core_turn = 1;
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic look(); #2; endtask

    task automatic core_set(input logic req, input logic [3:0] we, input logic [31:0] addr,
                            input logic [31:0] data, input logic lock, input logic lr, input logic sc);
        core_req_i = req; core_we_i = we; core_addr_i = addr; core_data_i = data;
        core_lock_i = lock; core_lr_i = lr; core_sc_i = sc;
    endtask

    task automatic dma_set(input logic req, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] data);
        dma_req_i = req; dma_we_i = we; dma_addr_i = addr; dma_data_i = data;
    endtask

    initial begin
        reset_n = 1'b0;
        core_set(0, 4'h0, 0, 0, 0, 0, 0);
        dma_set(0, 4'h0, 0, 0);
        for (int i = 0; i < 256; i++) begin sram[i] = init_val(i); ref_mem[i] = init_val(i); end
        repeat (3) @(posedge clk);
        #1;
        core_set(1, 4'h0, 32'h100, 0, 0, 0, 0);
        look();
        chk("rst_core_gnt", core_gnt_o, 0);
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_core_data", core_data_o, 0);

        // T1: plain core read
        tick(); reset_n = 1'b1;
        look(); chk("t1_gnt", core_gnt_o, 1); chk("t1_addr", mem_addr_o, 32'h100);
        tick(); core_set(0, 4'h0, 0, 0, 0, 0, 0);
        look(); chk("t1_rvalid", core_rvalid_o, 1); chk("t1_data", core_data_o, 32'hDEADBEEF);

        // T2: contention alternates, core first
        tick(); dma_set(1, 4'h0, 32'h200, 0);
        look(); chk("t2_pre_dma", dma_gnt_o, 1);
        tick(); core_set(1, 4'h0, 32'h104, 0, 0, 0, 0); dma_set(1, 4'h0, 32'h204, 0);
        look(); chk("t2_c0_core", core_gnt_o, 1); chk("t2_c0_dma", dma_gnt_o, 0);
        tick(); look(); chk("t2_c1_core", core_gnt_o, 0); chk("t2_c1_dma", dma_gnt_o, 1);
        tick(); look(); chk("t2_c2_core", core_gnt_o, 1); chk("t2_c2_dma", dma_gnt_o, 0);
        tick(); core_set(0, 4'h0, 0, 0, 0, 0, 0); dma_set(0, 4'h0, 0, 0);

        // T3: locked read blocks DMA until releasing write
        tick(); dma_set(1, 4'h0, 32'h204, 0);
        tick(); core_set(1, 4'h0, 32'h40, 0, 1, 0, 0); dma_set(1, 4'h0, 32'h40, 0);
        look(); chk("t3_c0_core", core_gnt_o, 1); chk("t3_c0_dma", dma_gnt_o, 0);
        tick(); core_set(0, 4'h0, 0, 0, 0, 0, 0);
        look(); chk("t3_c1_dma", dma_gnt_o, 0);
        tick(); look(); chk("t3_c2_dma", dma_gnt_o, 0);
        tick(); core_set(1, 4'hF, 32'h40, 32'hCAFEF00D, 0, 0, 0);
        look(); chk("t3_c3_core", core_gnt_o, 1); chk("t3_c3_dma", dma_gnt_o, 0);
        tick(); core_set(0, 4'h0, 0, 0, 0, 0, 0);
        look(); chk("t3_c4_dma", dma_gnt_o, 1);
        tick(); dma_set(0, 4'h0, 0, 0);
        look(); chk("t3_rvalid", dma_rvalid_o, 1); chk("t3_data", dma_data_o, 32'hCAFEF00D);

        // T4: forced release after LT locked cycles
        tick(); core_set(1, 4'h0, 32'h40, 0, 1, 0, 0);
        look(); chk("t4_lock_gnt", core_gnt_o, 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) begin core_set(0, 4'h0, 0, 0, 0, 0, 0); dma_set(1, 4'h0, 32'h48, 0); end
            look(); chk("t4_locked_dma", dma_gnt_o, 0); chk("t4_locked_to", lock_timeout_o, 0);
        end
        tick(); look(); chk("t4_pulse", lock_timeout_o, 1); chk("t4_dma_gnt", dma_gnt_o, 1);
        tick(); dma_set(0, 4'h0, 0, 0);
        look(); chk("t4_pulse_end", lock_timeout_o, 0);

        // T5: LR/SC with and without intervening DMA write
        tick(); core_set(1, 4'h0, 32'h80, 0, 0, 1, 0);
        tick(); core_set(0, 4'h0, 0, 0, 0, 0, 0); dma_set(1, 4'hF, 32'h80, 32'h12345678);
        tick(); dma_set(0, 4'h0, 0, 0); core_set(1, 4'hF, 32'h80, 32'hAAAA5555, 0, 0, 1);
        look(); chk("t5_sc1_gnt", core_gnt_o, 1); chk("t5_sc1_en", mem_en_o, 1); chk("t5_sc1_we", mem_we_o, 0);
        tick(); core_set(0, 4'h0, 0, 0, 0, 0, 0);
        look(); chk("t5_sc1_done", sc_done_o, 1); chk("t5_sc1_fail", sc_fail_o, 1);
        tick(); core_set(1, 4'h0, 32'h80, 0, 0, 1, 0);
        tick(); core_set(1, 4'hF, 32'h80, 32'hAAAA5555, 0, 0, 1);
        look(); chk("t5_lr2_data", core_data_o, 32'h12345678); chk("t5_sc2_we", mem_we_o, 4'hF);
        tick(); core_set(0, 4'h0, 0, 0, 0, 0, 0);
        look(); chk("t5_sc2_done", sc_done_o, 1); chk("t5_sc2_fail", sc_fail_o, 0);
        tick(); core_set(1, 4'h0, 32'h80, 0, 0, 0, 0);
        tick(); core_set(0, 4'h0, 0, 0, 0, 0, 0);
        look(); chk("t5_readback", core_data_o, 32'hAAAA5555);

        // T6: reset right after a locked read grant
        tick(); core_set(1, 4'h0, 32'h20, 0, 1, 0, 0);
        look(); chk("t6_gnt", core_gnt_o, 1);
        @(negedge clk); #1;
        reset_n = 1'b0; core_set(0, 4'h0, 0, 0, 0, 0, 0); dma_set(1, 4'h0, 32'h24, 0);
        tick(); look(); chk("t6_no_rvalid", core_rvalid_o, 0); chk("t6_rst_dma", dma_gnt_o, 0);
        tick(); reset_n = 1'b1;
        look(); chk("t6_no_rvalid2", core_rvalid_o, 0); chk("t6_idle_dma", dma_gnt_o, 1);
        tick(); dma_set(0, 4'h0, 0, 0);
        look(); chk("t6_dma_rvalid", dma_rvalid_o, 1); chk("t6_dma_data", dma_data_o, init_val(9));
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
